// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals around the memory port arbiter.
// The master modport is the arbiter's view; slave is the view of the surrounding
// caches and memory controller.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32
);
  // I-cache line fill
  logic                  ir_req;
  logic [ADDR_WIDTH-1:0] ir_addr;
  logic                  ir_rvalid;
  logic                  ir_last;
  // D-cache line fill
  logic                  dr_req;
  logic [ADDR_WIDTH-1:0] dr_addr;
  logic                  dr_rvalid;
  logic                  dr_last;
  // Shared read data
  logic [DATA_WIDTH-1:0] rdata;
  // D-cache write-back
  logic                  dw_req;
  logic [ADDR_WIDTH-1:0] dw_addr;
  logic [DATA_WIDTH-1:0] dw_wdata;
  logic                  dw_wready;
  logic                  dw_last;
  // Memory controller port
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_gnt;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_wready;

  modport master (
    input  ir_req, ir_addr, dr_req, dr_addr, dw_req, dw_addr, dw_wdata,
           mem_gnt, mem_rdata, mem_rvalid, mem_wready,
    output ir_rvalid, ir_last, dr_rvalid, dr_last, rdata, dw_wready, dw_last,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output ir_req, ir_addr, dr_req, dr_addr, dw_req, dw_addr, dw_wdata,
           mem_gnt, mem_rdata, mem_rvalid, mem_wready,
    input  ir_rvalid, ir_last, dr_rvalid, dr_last, rdata, dw_wready, dw_last,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: grants one of I-fill, D-fill or D-write-back for a whole
// burst, runs the address phase and the data beats, and steers the handshakes to
// the owner. D-side wins by default; a starvation counter forces an I-side grant
// after STARVE_LIMIT consecutive D-side grants made while the I-side waits.
module mem_port_arbiter #(
  parameter int ADDR_WIDTH   = 26,
  parameter int DATA_WIDTH   = 32,
  parameter int BURST_LEN    = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.master   bus
);

  localparam int BEAT_W   = $clog2(BURST_LEN);
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [BEAT_W-1:0]   LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
  localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, ADDR, RBURST, WBURST} state_t;
  typedef enum logic [1:0] {OWN_IR, OWN_DR, OWN_DW} owner_t;

  state_t                state;
  owner_t                owner;
  logic [BEAT_W-1:0]     beat_cnt;
  logic [STARVE_W-1:0]   starve_cnt;
  logic                  mem_req_q;
  logic                  mem_we_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  logic                  grant_valid;
  owner_t                grant_owner;
  logic [ADDR_WIDTH-1:0] grant_addr;

  logic rd_beat;
  logic wr_beat;
  logic beat_last;

  // Pick the winner among the current requests; only used while in IDLE.
  always_comb begin
    grant_valid = 1'b0;
    grant_owner = OWN_IR;
    grant_addr  = '0;
    if (bus.ir_req && starve_cnt == STARVE_MAX) begin
      grant_valid = 1'b1;
      grant_owner = OWN_IR;
      grant_addr  = bus.ir_addr;
    end else if (bus.dw_req) begin
      grant_valid = 1'b1;
      grant_owner = OWN_DW;
      grant_addr  = bus.dw_addr;
    end else if (bus.dr_req) begin
      grant_valid = 1'b1;
      grant_owner = OWN_DR;
      grant_addr  = bus.dr_addr;
    end else if (bus.ir_req) begin
      grant_valid = 1'b1;
      grant_owner = OWN_IR;
      grant_addr  = bus.ir_addr;
    end
  end

  assign rd_beat   = (state == RBURST) && bus.mem_rvalid;
  assign wr_beat   = (state == WBURST) && bus.mem_wready;
  assign beat_last = (beat_cnt == LAST_BEAT);

  // Burst sequencer: grant, address phase, data beats, starvation bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= OWN_IR;
      beat_cnt   <= '0;
      starve_cnt <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      addr_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner     <= grant_owner;
            addr_q    <= grant_addr;
            beat_cnt  <= '0;
            mem_req_q <= 1'b1;
            mem_we_q  <= (grant_owner == OWN_DW);
            state     <= ADDR;
            if (grant_owner == OWN_IR || !bus.ir_req) begin
              starve_cnt <= '0;
            end else if (starve_cnt != STARVE_MAX) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
          end
        end
        ADDR: begin
          if (bus.mem_gnt) begin
            mem_req_q <= 1'b0;
            state     <= (owner == OWN_DW) ? WBURST : RBURST;
          end
        end
        RBURST: begin
          if (rd_beat) begin
            if (beat_last) begin
              beat_cnt <= '0;
              mem_we_q <= 1'b0;
              addr_q   <= '0;
              state    <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        WBURST: begin
          if (wr_beat) begin
            if (beat_last) begin
              beat_cnt <= '0;
              mem_we_q <= 1'b0;
              addr_q   <= '0;
              state    <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;

  assign bus.rdata     = rd_beat ? bus.mem_rdata : '0;
  assign bus.ir_rvalid = rd_beat && (owner == OWN_IR);
  assign bus.ir_last   = rd_beat && (owner == OWN_IR) && beat_last;
  assign bus.dr_rvalid = rd_beat && (owner == OWN_DR);
  assign bus.dr_last   = rd_beat && (owner == OWN_DR) && beat_last;

  assign bus.mem_wdata = (state == WBURST) ? bus.dw_wdata : '0;
  assign bus.dw_wready = wr_beat;
  assign bus.dw_last   = wr_beat && beat_last;

endmodule
